// File: rtl/spi_fast_proto.sv
// spi_fast_proto: protocol front-end downstream of the fast SPI slave core (user clock domain).
// Frames the received byte stream into transactions, where the first byte after CS assertion is
// the command and the rest are payload. It forwards every byte on a write-strobe bus, flags the
// end of each transaction, and feeds the core's transmit byte from a small response FIFO. When
// the FIFO is empty the core is given a fill byte.
//
// Ports:
//   clk, rst                  user clock, asynchronous active-high reset
//   spi_rx_data/spi_rx_stb    received byte and one-cycle strobe from the core
//   spi_tx_data/spi_tx_ack    next transmit byte to the core; core consumed it
//   spi_csn_fall/spi_csn_rise CS assert / deassert pulses from the core
//   pw_wdata/pw_wcmd/pw_wstb  forwarded byte, command flag, one-cycle strobe
//   pw_end                    one-cycle end-of-transaction pulse
//   resp_data/resp_valid      response FIFO push
//   resp_ready                response FIFO not full
//   resp_underrun             pulse: core consumed a byte while the FIFO was empty
//   xfer_bytes                bytes received in the current/last transaction (saturating)
module spi_fast_proto #(
  parameter int unsigned RESP_AW   = 2,
  parameter logic [7:0]  FILL_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  spi_rx_data,
  input  logic        spi_rx_stb,
  output logic [7:0]  spi_tx_data,
  input  logic        spi_tx_ack,
  input  logic        spi_csn_rise,
  input  logic        spi_csn_fall,
  output logic [7:0]  pw_wdata,
  output logic        pw_wcmd,
  output logic        pw_wstb,
  output logic        pw_end,
  input  logic [7:0]  resp_data,
  input  logic        resp_valid,
  output logic        resp_ready,
  output logic        resp_underrun,
  output logic [15:0] xfer_bytes
);

  localparam int unsigned Depth = 1 << RESP_AW;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  state_e state_q, state_d;

  logic fwd;        // forward this cycle's received byte
  logic is_cmd;     // forwarded byte is the command byte
  logic end_now;    // rise while in DATA with no coincident byte
  logic end_later;  // rise coincident with a byte: pw_end follows that byte's strobe
  logic clr_cnt;    // transaction (re)start

  logic end_pend_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A rise ends the transaction even if a fall arrives in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (spi_csn_fall) state_d = StCmd;
      StCmd: begin
        if (spi_csn_rise)      state_d = StIdle;
        else if (spi_csn_fall) state_d = StCmd;
        else if (spi_rx_stb)   state_d = StData;
      end
      StData: begin
        if (spi_csn_rise)      state_d = StIdle;
        else if (spi_csn_fall) state_d = StCmd;
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded actions
  always_comb begin
    fwd       = 1'b0;
    is_cmd    = (state_q == StCmd);
    end_now   = 1'b0;
    end_later = 1'b0;
    clr_cnt   = 1'b0;
    if (state_q == StIdle) begin
      clr_cnt = spi_csn_fall;
    end else if (spi_csn_rise) begin
      fwd       = spi_rx_stb;
      end_later = spi_rx_stb;
      end_now   = !spi_rx_stb && (state_q == StData);
    end else if (spi_csn_fall) begin
      // Missed rise: restart silently, dropping any coincident byte.
      clr_cnt = 1'b1;
    end else begin
      fwd = spi_rx_stb;
    end
  end

  // Registered write-strobe bus and byte counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pw_wdata   <= 8'h00;
      pw_wcmd    <= 1'b0;
      pw_wstb    <= 1'b0;
      pw_end     <= 1'b0;
      end_pend_q <= 1'b0;
      xfer_bytes <= 16'h0000;
    end else begin
      pw_wstb    <= fwd;
      end_pend_q <= end_later;
      pw_end     <= end_now | end_pend_q;
      if (fwd) begin
        pw_wdata <= spi_rx_data;
        pw_wcmd  <= is_cmd;
      end
      if (clr_cnt) begin
        xfer_bytes <= 16'h0000;
      end else if (fwd && (xfer_bytes != 16'hFFFF)) begin
        xfer_bytes <= xfer_bytes + 16'd1;
      end
    end
  end

  // Response FIFO
  logic [7:0]         mem [Depth];
  logic [RESP_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [RESP_AW:0]   cnt_q;
  logic               empty, full, pop, push;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (RESP_AW+1)'(Depth));
  assign pop   = spi_tx_ack && !empty;
  // A push into a full FIFO is still taken when a pop frees a slot in the same cycle.
  assign push  = resp_valid && (!full || pop) && !spi_csn_rise;

  assign resp_ready  = !full;
  assign spi_tx_data = empty ? FILL_BYTE : mem[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      resp_underrun <= 1'b0;
    end else begin
      resp_underrun <= spi_tx_ack && empty;
      if (spi_csn_rise) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= resp_data;
  end

endmodule
